// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper.
// Contents:
//   state_e          - sweeper FSM states
//   MODE_SOP/POS     - term-mask interpretation (minterms / maxterms)
//   rows(n)          - number of truth-table rows for n inputs (2^n)
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_SOP = 1'b0;
  localparam logic MODE_POS = 1'b1;

  function automatic int rows(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_row_eval.sv
// Combinational evaluation of one truth-table row.
// Ports:
//   mask  in  rows(N_IN)  term mask, bit i belongs to row i
//   mode  in  1           MODE_SOP: f = mask[idx]; MODE_POS: f = ~mask[idx]
//   idx   in  N_IN        row index (input vector, MSB = first variable)
//   f     out 1           function value for row idx
module tt_row_eval
  import tt_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [rows(N_IN)-1:0] mask,
  input  logic                  mode,
  input  logic [N_IN-1:0]       idx,
  output logic                  f
);

  // In POS form a set mask bit marks a maxterm, i.e. a row where f is 0.
  assign f = (mode == MODE_POS) ? ~mask[idx] : mask[idx];

endmodule

// File: rtl/truth_table_sweeper.sv
// Sequential truth-table sweeper for an N_IN-input Boolean function.
// Latches a term mask and mode on start, then streams every row in
// ascending order over a valid/ready interface, counting rows with f=1.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        begin a sweep (honoured only when idle)
//   abort        cancel a running sweep (no done pulse)
//   cfg_mask     term mask, bit i refers to row i
//   cfg_mode     0 = sum-of-products, 1 = product-of-sums
//   busy         high while running or signalling done
//   out_valid    row available (suppressed in the cycle abort is high)
//   out_ready    consumer accepts the current row
//   out_idx      current row index (= input vector)
//   out_f        function value for out_idx
//   done         one-cycle pulse after the last row is accepted
//   ones_count   accepted rows with f=1 in the current or last sweep
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [rows(N_IN)-1:0] cfg_mask,
  input  logic                  cfg_mode,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_IN-1:0]       out_idx,
  output logic                  out_f,
  output logic                  done,
  output logic [N_IN:0]         ones_count
);

  localparam int ROWS = rows(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(ROWS - 1);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [ROWS-1:0]     mask_q, mask_d;
  logic                mode_q, mode_d;
  logic [N_IN:0]       ones_q, ones_d;
  logic                row_f;
  logic                beat;

  tt_row_eval #(
    .N_IN (N_IN)
  ) u_row_eval (
    .mask (mask_q),
    .mode (mode_q),
    .idx  (idx_q),
    .f    (row_f)
  );

  // abort gates valid combinationally so a cancelled row is never handed over.
  assign out_valid  = (state_q == ST_RUN) & ~abort;
  assign beat       = out_valid & out_ready;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign out_idx    = idx_q;
  assign out_f      = row_f;
  assign ones_count = ones_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    ones_d  = ones_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = cfg_mask;
          mode_d  = cfg_mode;
          idx_d   = '0;
          ones_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          ones_d = ones_q + (N_IN+1)'(row_f);
          // idx is held on the last row so it never wraps within a sweep.
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + N_IN'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      ones_q  <= ones_d;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- N_IN = 3 instance ----------------
  logic       start, abort, cfg_mode, out_ready;
  logic [7:0] cfg_mask;
  logic       busy, out_valid, out_f, done;
  logic [2:0] out_idx;
  logic [3:0] ones_count;

  truth_table_sweeper #(.N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_mask(cfg_mask), .cfg_mode(cfg_mode), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_f(out_f), .done(done), .ones_count(ones_count)
  );

  // ---------------- N_IN = 1 instance ----------------
  logic       s1_start, s1_mode, s1_ready;
  logic [1:0] s1_mask;
  logic       s1_busy, s1_valid, s1_f, s1_done;
  logic [0:0] s1_idx;
  logic [1:0] s1_ones;

  truth_table_sweeper #(.N_IN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(1'b0),
    .cfg_mask(s1_mask), .cfg_mode(s1_mode), .busy(s1_busy),
    .out_valid(s1_valid), .out_ready(s1_ready), .out_idx(s1_idx),
    .out_f(s1_f), .done(s1_done), .ones_count(s1_ones)
  );

  // ---------------- N_IN = 8 instance ----------------
  logic         s8_start, s8_mode, s8_ready;
  logic [255:0] s8_mask;
  logic         s8_busy, s8_valid, s8_f, s8_done;
  logic [7:0]   s8_idx;
  logic [8:0]   s8_ones;

  truth_table_sweeper #(.N_IN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .abort(1'b0),
    .cfg_mask(s8_mask), .cfg_mode(s8_mode), .busy(s8_busy),
    .out_valid(s8_valid), .out_ready(s8_ready), .out_idx(s8_idx),
    .out_f(s8_f), .done(s8_done), .ones_count(s8_ones)
  );

  // ---------------- reference model ----------------
  // Truth value of row i straight from the minterm/maxterm definition.
  function automatic logic model_f(input logic [7:0] m, input logic md, input int i);
    logic bit_i;
    bit_i = m[i];
    return md ? !bit_i : bit_i;
  endfunction

  function automatic int model_count(input logic [7:0] m, input logic md);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(model_f(m, md, i));
    return n;
  endfunction

  // ---------------- sweep driver (records observations only) ----------------
  logic [2:0] r_idx[$];
  logic       r_f[$];
  int r_done_cnt, r_done_cyc, r_end_cyc, r_abort_cyc, r_stall_bad;
  logic r_abort_valid, r_ended;
  logic [3:0] r_ones;

  // ready_kind: 0 always ready, 1 random, 2 pattern 1,0,0,1,0,0,...
  task automatic sweep3(input logic [7:0] mask, input logic mode, input int ready_kind,
                        input int abort_after, input bit disturb, input bit abort_with_start);
    int beats = 0;
    bit abort_used = 0, prev_stall = 0;
    logic [2:0] prev_idx = '0;
    logic prev_f = 1'b0;
    r_idx.delete(); r_f.delete();
    r_done_cnt = 0; r_done_cyc = -1; r_end_cyc = -1; r_abort_cyc = -1;
    r_stall_bad = 0; r_abort_valid = 1'b0; r_ended = 1'b0;
    cfg_mask = mask; cfg_mode = mode; start = 1'b1; abort = abort_with_start; out_ready = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      abort = 1'b0;
      if (!busy) begin start = 1'b0; r_ended = 1'b1; r_end_cyc = c; break; end
      start = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
      if (disturb) begin cfg_mask = 8'($urandom); cfg_mode = 1'($urandom_range(0, 1)); end
      if (done) begin r_done_cnt++; r_done_cyc = c; end
      case (ready_kind)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (c % 3 == 1);
      endcase
      if (!abort_used && abort_after >= 0 && beats == abort_after && !done) begin
        abort = 1'b1; abort_used = 1; r_abort_cyc = c;
      end
      #1;
      if (abort) r_abort_valid = out_valid;
      if (prev_stall && out_valid && (out_idx !== prev_idx || out_f !== prev_f)) r_stall_bad++;
      if (out_valid && out_ready) begin
        r_idx.push_back(out_idx); r_f.push_back(out_f); beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_idx = out_idx; prev_f = out_f;
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    r_ones = ones_count;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (ones_count !== 4'd0) begin failures++; $display("FAIL reset_ones got=%0d want=0", ones_count); end
    checks++; if (out_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d want=0", out_idx); end
    checks++; if (out_f !== 1'b0) begin failures++; $display("FAIL reset_f got=%b want=0", out_f); end
  endtask

  task automatic test_pos_example();
    logic [7:0] m = 8'b0010_1000;
    sweep3(m, 1'b1, 0, -1, 0, 0);
    checks++; if (r_ended !== 1'b1) begin failures++; $display("FAIL pos_timeout ended=%b want=1", r_ended); end
    checks++; if (r_idx.size() != 8) begin failures++; $display("FAIL pos_beats got=%0d want=8", r_idx.size()); end
    for (int i = 0; i < r_idx.size(); i++) begin
      checks++; if (r_idx[i] !== 3'(i)) begin failures++; $display("FAIL pos_idx[%0d] got=%0d want=%0d", i, r_idx[i], i); end
      checks++; if (r_f[i] !== model_f(m, 1'b1, i)) begin failures++; $display("FAIL pos_f[%0d] got=%b want=%b", i, r_f[i], model_f(m, 1'b1, i)); end
    end
    checks++; if (r_done_cnt != 1) begin failures++; $display("FAIL pos_done_cnt got=%0d want=1", r_done_cnt); end
    checks++; if (r_done_cyc != 9) begin failures++; $display("FAIL pos_done_cycle got=%0d want=9", r_done_cyc); end
    checks++; if (r_ones !== 4'd6) begin failures++; $display("FAIL pos_ones got=%0d want=6", r_ones); end
  endtask

  task automatic test_xor();
    logic [7:0] m = 8'b1001_0110;
    for (int md = 0; md < 2; md++) begin
      sweep3(m, 1'(md), 0, -1, 0, 0);
      checks++; if (r_idx.size() != 8) begin failures++; $display("FAIL xor%0d_beats got=%0d want=8", md, r_idx.size()); end
      for (int i = 0; i < r_f.size(); i++) begin
        checks++; if (r_f[i] !== model_f(m, 1'(md), i)) begin failures++; $display("FAIL xor%0d_f[%0d] got=%b want=%b", md, i, r_f[i], model_f(m, 1'(md), i)); end
      end
      checks++; if (r_ones !== 4'd4) begin failures++; $display("FAIL xor%0d_ones got=%0d want=4", md, r_ones); end
      checks++; if (r_done_cnt != 1) begin failures++; $display("FAIL xor%0d_done_cnt got=%0d want=1", md, r_done_cnt); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] m = 8'($urandom);
    sweep3(m, 1'b0, 2, -1, 0, 0);
    checks++; if (r_stall_bad != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d want=0", r_stall_bad); end
    checks++; if (r_idx.size() != 8) begin failures++; $display("FAIL bp_beats got=%0d want=8", r_idx.size()); end
    for (int i = 0; i < r_idx.size(); i++) begin
      checks++; if (r_idx[i] !== 3'(i) || r_f[i] !== model_f(m, 1'b0, i)) begin
        failures++; $display("FAIL bp_row[%0d] got=%0d/%b want=%0d/%b", i, r_idx[i], r_f[i], i, model_f(m, 1'b0, i));
      end
    end
    checks++; if (r_done_cnt != 1) begin failures++; $display("FAIL bp_done_cnt got=%0d want=1", r_done_cnt); end
    checks++; if (r_ones !== 4'(model_count(m, 1'b0))) begin failures++; $display("FAIL bp_ones got=%0d want=%0d", r_ones, model_count(m, 1'b0)); end
  endtask

  task automatic test_abort();
    sweep3(8'hFF, 1'b0, 0, 3, 0, 0);
    checks++; if (r_abort_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b want=0", r_abort_valid); end
    checks++; if (r_end_cyc != r_abort_cyc + 1) begin failures++; $display("FAIL abort_idle_next got=%0d want=%0d", r_end_cyc, r_abort_cyc + 1); end
    checks++; if (r_done_cnt != 0) begin failures++; $display("FAIL abort_done got=%0d want=0", r_done_cnt); end
    checks++; if (r_idx.size() != 3) begin failures++; $display("FAIL abort_beats got=%0d want=3", r_idx.size()); end
    checks++; if (r_ones !== 4'd3) begin failures++; $display("FAIL abort_ones got=%0d want=3", r_ones); end
    sweep3(8'hFF, 1'b0, 0, -1, 0, 0);
    checks++; if (r_ones !== 4'd8) begin failures++; $display("FAIL abort_rerun_ones got=%0d want=8", r_ones); end
    checks++; if (r_done_cnt != 1) begin failures++; $display("FAIL abort_rerun_done got=%0d want=1", r_done_cnt); end
  endtask

  task automatic test_start_abort_idle();
    logic [7:0] m = 8'($urandom);
    sweep3(m, 1'b1, 0, -1, 0, 1);
    checks++; if (r_idx.size() != 8) begin failures++; $display("FAIL sa_beats got=%0d want=8", r_idx.size()); end
    checks++; if (r_ones !== 4'(model_count(m, 1'b1))) begin failures++; $display("FAIL sa_ones got=%0d want=%0d", r_ones, model_count(m, 1'b1)); end
  endtask

  task automatic test_disturb();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] m = 8'($urandom);
      logic md = 1'($urandom_range(0, 1));
      sweep3(m, md, 1, -1, 1, 0);
      checks++; if (r_idx.size() != 8) begin failures++; $display("FAIL dist%0d_beats got=%0d want=8", k, r_idx.size()); end
      for (int i = 0; i < r_idx.size(); i++) begin
        checks++; if (r_idx[i] !== 3'(i) || r_f[i] !== model_f(m, md, i)) begin
          failures++; $display("FAIL dist%0d_row[%0d] got=%0d/%b want=%0d/%b", k, i, r_idx[i], r_f[i], i, model_f(m, md, i));
        end
      end
      checks++; if (r_ones !== 4'(model_count(m, md))) begin failures++; $display("FAIL dist%0d_ones got=%0d want=%0d", k, r_ones, model_count(m, md)); end
      checks++; if (r_done_cnt != 1) begin failures++; $display("FAIL dist%0d_done got=%0d want=1", k, r_done_cnt); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      logic [7:0] m = 8'($urandom);
      logic md = 1'($urandom_range(0, 1));
      sweep3(m, md, 1, -1, 0, 0);
      checks++; if (r_stall_bad != 0) begin failures++; $display("FAIL rnd%0d_stall got=%0d want=0", k, r_stall_bad); end
      checks++; if (r_idx.size() != 8) begin failures++; $display("FAIL rnd%0d_beats got=%0d want=8", k, r_idx.size()); end
      for (int i = 0; i < r_f.size(); i++) begin
        checks++; if (r_f[i] !== model_f(m, md, i)) begin failures++; $display("FAIL rnd%0d_f[%0d] got=%b want=%b", k, i, r_f[i], model_f(m, md, i)); end
      end
      checks++; if (r_ones !== 4'(model_count(m, md))) begin failures++; $display("FAIL rnd%0d_ones got=%0d want=%0d", k, r_ones, model_count(m, md)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m = 8'($urandom) | 8'h0F;
    bit found = 0;
    cfg_mask = m; cfg_mode = 1'b0; start = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && out_valid && out_idx == 3'd4) begin found = 1; break; end
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL rstmid_reach_row4 got=%b want=1", found); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctrl got=%b%b%b want=000", busy, out_valid, done);
    end
    checks++; if (ones_count !== 4'd0 || out_idx !== 3'd0 || out_f !== 1'b0) begin
      failures++; $display("FAIL rstmid_data got=%0d/%0d/%b want=0/0/0", ones_count, out_idx, out_f);
    end
    out_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m = 8'($urandom);
    sweep3(m, 1'b1, 0, -1, 0, 0);
    checks++; if (r_idx.size() != 8 || r_idx[0] !== 3'd0) begin failures++; $display("FAIL rstmid_rerun_beats got=%0d want=8", r_idx.size()); end
    checks++; if (r_ones !== 4'(model_count(m, 1'b1))) begin failures++; $display("FAIL rstmid_rerun_ones got=%0d want=%0d", r_ones, model_count(m, 1'b1)); end
    checks++; if (r_done_cnt != 1) begin failures++; $display("FAIL rstmid_rerun_done got=%0d want=1", r_done_cnt); end
  endtask

  task automatic test_n1();
    int beats = 0, dcnt = 0, bad = 0;
    bit ended = 0;
    s1_mask = 2'b00; s1_mode = 1'b0; s1_ready = 1'b1; s1_start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      s1_start = 1'b0;
      if (!s1_busy) begin ended = 1; break; end
      if (s1_done) dcnt++;
      #1;
      if (s1_valid && s1_ready) begin
        if (int'(s1_idx) != beats || s1_f !== 1'b0) bad++;
        beats++;
      end
    end
    checks++; if (!ended) begin failures++; $display("FAIL n1_timeout ended=0 want=1"); end
    checks++; if (beats != 2) begin failures++; $display("FAIL n1_beats got=%0d want=2", beats); end
    checks++; if (dcnt != 1) begin failures++; $display("FAIL n1_done got=%0d want=1", dcnt); end
    checks++; if (bad != 0) begin failures++; $display("FAIL n1_rows got=%0d bad want=0", bad); end
    checks++; if (s1_ones !== 2'd0) begin failures++; $display("FAIL n1_ones got=%0d want=0", s1_ones); end
  endtask

  task automatic test_n8();
    for (int k = 0; k < 2; k++) begin
      int beats = 0, dcnt = 0, bad = 0, exp_ones = 0;
      bit ended = 0;
      logic md;
      logic [255:0] m = '0;
      md = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (k != 0) for (int w = 0; w < 8; w++) m[w*32 +: 32] = $urandom;
      for (int i = 0; i < 256; i++) exp_ones += int'(m[i] ^ md);
      s8_mask = m; s8_mode = md; s8_ready = 1'b1; s8_start = 1'b1;
      for (int c = 1; c <= 400; c++) begin
        @(negedge clk);
        s8_start = 1'b0;
        if (!s8_busy) begin ended = 1; break; end
        if (s8_done) dcnt++;
        #1;
        if (s8_valid && s8_ready) begin
          if (int'(s8_idx) != beats || s8_f !== (m[beats] ^ md)) bad++;
          beats++;
        end
      end
      checks++; if (!ended) begin failures++; $display("FAIL n8_%0d_timeout ended=0 want=1", k); end
      checks++; if (beats != 256) begin failures++; $display("FAIL n8_%0d_beats got=%0d want=256", k, beats); end
      checks++; if (dcnt != 1) begin failures++; $display("FAIL n8_%0d_done got=%0d want=1", k, dcnt); end
      checks++; if (bad != 0) begin failures++; $display("FAIL n8_%0d_rows got=%0d bad want=0", k, bad); end
      checks++; if (int'(s8_ones) != exp_ones) begin failures++; $display("FAIL n8_%0d_ones got=%0d want=%0d", k, s8_ones, exp_ones); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; cfg_mask = '0; cfg_mode = 1'b0; out_ready = 1'b0;
    s1_start = 1'b0; s1_mode = 1'b0; s1_mask = '0; s1_ready = 1'b0;
    s8_start = 1'b0; s8_mode = 1'b0; s8_mask = '0; s8_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_pos_example();
    test_xor();
    test_backpressure();
    test_abort();
    test_start_abort_idle();
    test_disturb();
    test_random();
    test_reset_mid();
    test_n1();
    test_n8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Parametrised sequential evaluator for an arbitrary N-input Boolean function.
- The function is loaded as a 2^N-bit term mask, interpreted as sum-of-products (minterms) or product-of-sums (maxterms).
- Sweeps every input combination in ascending order and streams one truth-table row per valid/ready beat.
- Counts rows where f=1 and pulses done at the end; used by exercise benches as a self-generating truth-table source.

Parameters:
- N_IN, 3, number of function inputs (1..8); row count ROWS = 2^N_IN.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  synchronous cancel of a running sweep.
- cfg_mask  in  ROWS  term mask; bit i refers to row i (inputs = binary i, MSB = first variable).
- cfg_mode  in  1  0 = SOP: f(i)=cfg_mask[i]; 1 = POS: f(i)=~cfg_mask[i].
- busy  out  1  high in RUN and DONE.
- out_valid  out  1  row available.
- out_ready  in  1  consumer accepts row.
- out_idx  out  N_IN  row index, equal to the input vector.
- out_f  out  1  function value for out_idx.
- done  out  1  one-cycle pulse after the last row is accepted.
- ones_count  out  N_IN+1  number of accepted rows with f=1 in the current or last sweep.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; idx=0; mask and mode regs=0; ones_count=0; busy, out_valid, done=0; out_f=0.
- FSM states:
  - IDLE: on start=1, latch cfg_mask/cfg_mode, clear idx and ones_count, go to RUN next cycle. cfg_* are sampled only at this edge.
  - RUN:
    - out_valid = ~abort (combinational gate on the registered RUN state).
    - out_idx = idx; out_f = mode ? ~mask[idx] : mask[idx].
    - Beat = out_valid & out_ready. On a beat, ones_count += out_f.
    - Beat with idx < ROWS-1: idx+1.
    - Beat with idx = ROWS-1: go to DONE, idx held.
  - DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. ones_count holds its final value until the next start.
- Latency: first row valid the cycle after start. With out_ready held high, ROWS beats follow back-to-back and done asserts at cycle ROWS+1 after start.
- Backpressure: while out_valid=1 and out_ready=0, out_idx and out_f are held stable; no skips, no duplicates.
- abort in RUN:
  - out_valid forced 0 that cycle; the beat is not counted.
  - Next cycle: IDLE, no done pulse, ones_count keeps its partial value.
  - abort in IDLE or DONE is ignored.
- start while busy is ignored. start and abort together in IDLE: start wins (abort has no effect in IDLE).
- idx never wraps within a sweep. ones_count width N_IN+1 holds ROWS for an all-ones function.
- Reset mid-sweep: immediate return to the reset state; no done pulse.
- out_idx reads 0 in IDLE after reset; otherwise it holds the last idx value.

Decomposition:
- Shared package tt_pkg:
  - state enum {ST_IDLE, ST_RUN, ST_DONE}.
  - constants MODE_SOP=0, MODE_POS=1.
  - localparam function rows(n)=1<<n.
- One natural sub-module: tt_row_eval, combinational mux plus mode inversion (mask, mode, idx -> f). It is reused by benches as the golden model.
- FSM, counter and handshake stay in the top module.

Test Plan:
- POS example, N_IN=3, cfg_mode=1, cfg_mask=8'b0010_1000, out_ready=1: rows 0..7 give f=1,1,1,0,1,0,1,1; done one cycle after row 7; ones_count=6.
- SOP, N_IN=3, cfg_mask=8'b1001_0110 (XOR3): f=0,1,1,0,1,0,0,1; ones_count=4. Repeat with cfg_mode=1 on the same mask: inverted values; ones_count=4.
- Backpressure: toggle out_ready 1,0,0,1,... during the first sweep. out_idx/out_f hold through every stall; exactly 8 beats, idx sequence 0..7, done after the 8th beat.
- Abort after 3 beats, mask=8'hFF SOP: out_valid=0 in the abort cycle; IDLE next cycle; no done; ones_count=3. A new start then runs a full sweep with ones_count=8.
- start pulses during RUN and cfg_mask changes mid-sweep: no effect on the stream or count. Async reset at row 4: all outputs 0 immediately; following sweep correct from row 0.
- N_IN=1 and N_IN=8 builds, all-zeros SOP mask: 2 and 256 beats respectively, ones_count=0, done exactly once.
